alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, pipelined successor to the team's 4-bit combinational ALU. Widens the datapath to `WIDTH` bits, extends the op set to eight operations with a full flag set, and registers the result behind a valid/ready handshake so it can sit directly in a streaming datapath between a producer (decoder/sequencer) and a consumer (register writeback). An optional accumulator mode chains results without a round trip through the producer.

## Interface

Parameters:
- `WIDTH`, default 8: operand and result width, minimum 2.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  operation presented
- `in_ready`  out  1  block accepts the operation this cycle
- `op`  in  3  operation select (see Operation)
- `a`  in  WIDTH  operand A
- `b`  in  WIDTH  operand B
- `use_acc`  in  1  substitute accumulator for A (only with `ALU_PIPE_ACC_EN`)
- `acc_clr`  in  1  synchronous accumulator clear (only with `ALU_PIPE_ACC_EN`)
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer takes the result
- `result`  out  WIDTH  operation result
- `carry`  out  1  carry / no-borrow / shifted-out bit
- `zero`  out  1  result == 0
- `neg`  out  1  `result[WIDTH-1]`
- `ovf`  out  1  signed overflow (ADD/SUB only, else 0)

## Operation

- Op codes:
  - 0: NOT, `~b`, carry 0
  - 1: AND, `a & b`, carry 0
  - 2: OR, `a | b`, carry 0
  - 3: ADD, `{carry,result} = a + b`
  - 4: SUB, `a + ~b + 1`; carry = 1 when there is no borrow
  - 5: XOR, carry 0
  - 6: SHL, `a << 1`, carry = `a[WIDTH-1]`
  - 7: SHR (logical), carry = `a[0]`
- ovf:
  - ADD: operands have the same sign and result sign differs.
  - SUB: operands have different signs and result sign differs from `a`.
- Arithmetic is computed at `WIDTH+1` bits. All results are truncated to `WIDTH`.
- Pipeline:
  - Stage 1 (S1) registers op, a, b and use_acc on handshake (`in_valid && in_ready`).
  - Stage 2 (S2) computes and registers result and flags. The outputs are the S2 registers directly.
- Flow control:
  - `s2_take = !out_valid || out_ready`
  - `in_ready = !s1_valid || s2_take`
  - S1 moves to S2 when `s1_valid && s2_take`.
  - Operations never drop, duplicate or reorder.
- While `out_valid && !out_ready`, all outputs hold stable.
- Reset (asserting `rst` at any time, including mid-operation):
  - Clears `s1_valid`, `out_valid`, `result`, all flags and the accumulator to 0 immediately.
  - In-flight operations are discarded.
  - `in_ready` is 1 from reset onward.

## Timing

- Latency: an op accepted at edge N shows `out_valid=1` after edge N+2 when there are no stalls.
- Throughput: 1 op/cycle while `out_ready=1`.
- Full stall: with `out_ready` held low, two ops are held (S1 and S2), then `in_ready=0`. `in_ready` is combinational on `out_ready`.
- Simultaneous events: S2 drain plus S1 advance plus a new accept in the same edge is legal, and the pipeline stays full.

## Configuration

- `ALU_PIPE_ACC_EN` defined:
  - Adds a `WIDTH`-bit accumulator, reset 0.
  - The accumulator loads S2's new result on every S1→S2 transfer.
  - When the transferring op has `use_acc=1`, operand A is the accumulator value before that transfer. Because the accumulator is updated at transfer time, it already holds the result of the immediately preceding op, so back-to-back chaining needs no stall.
  - `acc_clr` (sampled with an accepted op) zeroes the accumulator at that op's S1→S2 transfer, before the operand read. When `acc_clr` and `use_acc` are both set, A = 0.
- `ALU_PIPE_ACC_EN` undefined:
  - No accumulator register.
  - `use_acc` and `acc_clr` are ignored.
  - A always comes from the port.

## Test plan

- Reset: assert `rst` mid-stream with two ops in flight → `out_valid=0`, `result=0`, all flags 0, `in_ready=1`. The first op after release emerges 2 cycles after acceptance.
- ADD, `WIDTH=8`:
  - `0xFF+0x01` → result 0x00, carry=1, zero=1, ovf=0.
  - `0x7F+0x01` → result 0x80, neg=1, ovf=1, carry=0.
- SUB, `WIDTH=8`:
  - `0x80-0x01` → result 0x7F, carry=1, ovf=1.
  - `0x00-0x01` → result 0xFF, carry=0, neg=1.
- Logic/shift sweep, `a=0xA5`, `b=0x0F`, ops 0,1,2,5,6,7 → results 0xF0, 0x05, 0xAF, 0xAA, 0x4A (carry=1), 0x52 (carry=1).
- Backpressure: `out_ready=0`, offer 3 ADDs → `in_ready` drops after 2 accepts and outputs hold stable. Release `out_ready` → all 3 results in order, one per cycle.
- Accumulator (with `ALU_PIPE_ACC_EN`, `WIDTH=8`): ADD 5+3 with `acc_clr`, then back-to-back ADD `use_acc` b=2, then SHL `use_acc` → results 0x08, 0x0A, 0x14 with no bubbles. Without the macro, the same stimulus uses port A.

Source files
------------

// File: rtl/alu_pipe_if.sv
// Producer/consumer bundle for alu_pipe: operation request side plus result/flag side.
// The DUT takes the slave modport; the bench (producer + consumer) drives the master modport.
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             use_acc;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             neg;
    logic             ovf;

    modport master (
        output in_valid, op, a, b, use_acc, acc_clr, out_ready,
        input  in_ready, out_valid, result, carry, zero, neg, ovf
    );

    modport slave (
        input  in_valid, op, a, b, use_acc, acc_clr, out_ready,
        output in_ready, out_valid, result, carry, zero, neg, ovf
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined WIDTH-bit ALU (8 ops, carry/zero/neg/ovf) behind valid/ready handshakes.
// Define ALU_PIPE_ACC_EN to add the chaining accumulator (use_acc / acc_clr).
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input logic       clk,
    input logic       rst,
    alu_pipe_if.slave bus
);
    // Handshake: a transfer happens on a rising edge where valid && ready; the source
    // holds its payload stable while valid && !ready, and ready never depends on valid.
    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             zero_q;
    logic             neg_q;
    logic             ovf_q;

    logic             s2_take;
    logic             accept;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] res_d;
    logic             carry_d;
    logic             ovf_d;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;

    assign s2_take      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_take;
    assign accept       = bus.in_valid && bus.in_ready;

`ifdef ALU_PIPE_ACC_EN
    logic             s1_use_acc;
    logic             s1_acc_clr;
    logic [WIDTH-1:0] acc_q;

    // A clear takes effect before the operand read, so clr+use_acc yields A = 0.
    assign opa = s1_use_acc ? (s1_acc_clr ? '0 : acc_q) : s1_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_use_acc <= 1'b0;
            s1_acc_clr <= 1'b0;
            acc_q      <= '0;
        end else begin
            if (accept) begin
                s1_use_acc <= bus.use_acc;
                s1_acc_clr <= bus.acc_clr;
            end
            if (s1_valid && s2_take) begin
                acc_q <= res_d;
            end
        end
    end
`else
    logic unused_acc_ports;
    assign unused_acc_ports = bus.use_acc ^ bus.acc_clr;
    assign opa = s1_a;
`endif

    always_comb begin
        sum_w   = {1'b0, opa} + {1'b0, s1_b};
        diff_w  = {1'b0, opa} + {1'b0, ~s1_b} + (WIDTH + 1)'(1);
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        case (s1_op)
            3'd0: res_d = ~s1_b;
            3'd1: res_d = opa & s1_b;
            3'd2: res_d = opa | s1_b;
            3'd3: begin
                res_d   = sum_w[WIDTH-1:0];
                carry_d = sum_w[WIDTH];
                ovf_d   = (opa[WIDTH-1] == s1_b[WIDTH-1]) && (sum_w[WIDTH-1] != opa[WIDTH-1]);
            end
            3'd4: begin
                res_d   = diff_w[WIDTH-1:0];
                carry_d = diff_w[WIDTH];
                ovf_d   = (opa[WIDTH-1] != s1_b[WIDTH-1]) && (diff_w[WIDTH-1] != opa[WIDTH-1]);
            end
            3'd5: res_d = opa ^ s1_b;
            3'd6: begin
                res_d   = {opa[WIDTH-2:0], 1'b0};
                carry_d = opa[WIDTH-1];
            end
            default: begin
                res_d   = {1'b0, opa[WIDTH-1:1]};
                carry_d = opa[0];
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_op       <= '0;
            s1_a        <= '0;
            s1_b        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_op    <= bus.op;
                s1_a     <= bus.a;
                s1_b     <= bus.b;
            end else if (s2_take) begin
                s1_valid <= 1'b0;
            end
            // S2 only changes when it is free or being drained, which keeps outputs stable under stall.
            if (s2_take) begin
                out_valid_q <= s1_valid;
                if (s1_valid) begin
                    result_q <= res_d;
                    carry_q  <= carry_d;
                    zero_q   <= (res_d == '0);
                    neg_q    <= res_d[WIDTH-1];
                    ovf_q    <= ovf_d;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=8): reset, arithmetic flags, logic/shift sweep,
// backpressure and accumulator chaining (expectations follow ALU_PIPE_ACC_EN).
module tb_alu_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(8)) bus ();
    alu_pipe #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [2:0] v_op[8];
    logic [7:0] v_a[8];
    logic [7:0] v_b[8];
    logic       v_ua[8];
    logic       v_ac[8];
    logic [7:0] got_res[$];
    logic [3:0] got_flg[$];
    int         got_cyc[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.op        = 3'd0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.use_acc   = 1'b0;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic drive_vec(input int k);
        bus.in_valid = 1'b1;
        bus.op       = v_op[k];
        bus.a        = v_a[k];
        bus.b        = v_b[k];
        bus.use_acc  = v_ua[k];
        bus.acc_clr  = v_ac[k];
    endtask

    // Offers v_*[0..n-1] in order with out_ready=1 and records every consumed result.
    task automatic run_stream(input int n, input int max_cycles);
        int  k;
        logic fire_in;
        k = 0;
        got_res.delete();
        got_flg.delete();
        got_cyc.delete();
        bus.out_ready = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            if (k < n) drive_vec(k);
            else bus.in_valid = 1'b0;
            #1;
            fire_in = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                got_res.push_back(bus.result);
                got_flg.push_back({bus.carry, bus.zero, bus.neg, bus.ovf});
                got_cyc.push_back(c);
            end
            tick();
            if (fire_in) k++;
        end
        bus.in_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #12;
        total++;
        if (bus.out_valid !== 1'b0 || bus.result !== 8'h00 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_init: valid=%b result=%h in_ready=%b, want 0 00 1",
                     bus.out_valid, bus.result, bus.in_ready);
        end
        rst = 1'b0;
        tick();
        // Fill both stages under stall, then reset mid-cycle.
        bus.out_ready = 1'b0;
        v_op[0] = 3'd3; v_a[0] = 8'h7F; v_b[0] = 8'h01; v_ua[0] = 0; v_ac[0] = 0;
        v_op[1] = 3'd3; v_a[1] = 8'hFF; v_b[1] = 8'h01; v_ua[1] = 0; v_ac[1] = 0;
        drive_vec(0);
        tick();
        drive_vec(1);
        tick();
        bus.in_valid = 1'b0;
        tick();
        total++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.result !== 8'h80) begin
            bad++;
            $display("FAIL reset_fill: in_ready=%b valid=%b result=%h, want 0 1 80",
                     bus.in_ready, bus.out_valid, bus.result);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({bus.out_valid, bus.result, bus.carry, bus.zero, bus.neg, bus.ovf} !== 13'd0 ||
            bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid: valid=%b result=%h flags=%b%b%b%b in_ready=%b, want all 0, in_ready 1",
                     bus.out_valid, bus.result, bus.carry, bus.zero, bus.neg, bus.ovf, bus.in_ready);
        end
        #3;
        rst = 1'b0;
        tick();
        v_op[0] = 3'd3; v_a[0] = 8'h12; v_b[0] = 8'h34; v_ua[0] = 0; v_ac[0] = 0;
        run_stream(1, 6);
        total++;
        if (got_res.size() != 1 || got_res[0] !== 8'h46 || got_cyc[0] != 2) begin
            bad++;
            $display("FAIL reset_after: count=%0d result=%h cycle=%0d, want 1 46 2", got_res.size(),
                     (got_res.size() > 0) ? got_res[0] : 8'hxx, (got_cyc.size() > 0) ? got_cyc[0] : -1);
        end
    endtask

    task automatic test_alu_ops();
        // op, a, b, result, {carry,zero,neg,ovf}
        logic [2:0] t_op[10]  = '{3, 3, 4, 4, 0, 1, 2, 5, 6, 7};
        logic [7:0] t_a[10]   = '{8'hFF, 8'h7F, 8'h80, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        logic [7:0] t_b[10]   = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F};
        logic [7:0] t_res[10] = '{8'h00, 8'h80, 8'h7F, 8'hFF, 8'hF0, 8'h05, 8'hAF, 8'hAA, 8'h4A, 8'h52};
        logic [3:0] t_flg[10] = '{4'b1100, 4'b0011, 4'b1001, 4'b0010, 4'b0010,
                                  4'b0000, 4'b0010, 4'b0010, 4'b1000, 4'b1000};
        for (int i = 0; i < 10; i++) begin
            v_op[0] = t_op[i]; v_a[0] = t_a[i]; v_b[0] = t_b[i]; v_ua[0] = 0; v_ac[0] = 0;
            run_stream(1, 5);
            total++;
            if (got_res.size() != 1 || got_res[0] !== t_res[i] || got_flg[0] !== t_flg[i]) begin
                bad++;
                $display("FAIL alu_op[%0d] op=%0d a=%h b=%h: count=%0d result=%h cznv=%b, want %h %b",
                         i, t_op[i], t_a[i], t_b[i], got_res.size(),
                         (got_res.size() > 0) ? got_res[0] : 8'hxx,
                         (got_flg.size() > 0) ? got_flg[0] : 4'bxxxx, t_res[i], t_flg[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int   k;
        logic fire_in;
        logic [7:0] held;
        exp_q = '{8'h11, 8'h22, 8'h10};
        v_op[0] = 3'd3; v_a[0] = 8'h10; v_b[0] = 8'h01; v_ua[0] = 0; v_ac[0] = 0;
        v_op[1] = 3'd3; v_a[1] = 8'h20; v_b[1] = 8'h02; v_ua[1] = 0; v_ac[1] = 0;
        v_op[2] = 3'd3; v_a[2] = 8'hF0; v_b[2] = 8'h20; v_ua[2] = 0; v_ac[2] = 0;
        k = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (k < 3) drive_vec(k);
            #1;
            fire_in = bus.in_valid && bus.in_ready;
            tick();
            if (fire_in) k++;
        end
        total++;
        if (k != 2 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.result !== 8'h11) begin
            bad++;
            $display("FAIL bp_stall: accepts=%0d in_ready=%b valid=%b result=%h, want 2 0 1 11",
                     k, bus.in_ready, bus.out_valid, bus.result);
        end
        held = bus.result;
        tick();
        tick();
        total++;
        if (bus.result !== 8'h11 || bus.out_valid !== 1'b1 || bus.carry !== 1'b0 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold: result=%h (was %h) valid=%b carry=%b in_ready=%b, want 11 1 0 0",
                     bus.result, held, bus.out_valid, bus.carry, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        got_res.delete();
        got_cyc.delete();
        for (int c = 0; c < 8; c++) begin
            if (k < 3) drive_vec(k);
            else bus.in_valid = 1'b0;
            #1;
            fire_in = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                got_res.push_back(bus.result);
                got_cyc.push_back(c);
            end
            tick();
            if (fire_in) k++;
        end
        bus.in_valid = 1'b0;
        total++;
        if (got_res.size() != 3) begin
            bad++;
            $display("FAIL bp_count: results=%0d, want 3", got_res.size());
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= got_res.size() || got_res[i] !== exp_q[i] || got_cyc[i] != i) begin
                bad++;
                $display("FAIL bp_order[%0d]: result=%h cycle=%0d, want %h at %0d", i,
                         (i < got_res.size()) ? got_res[i] : 8'hxx,
                         (i < got_cyc.size()) ? got_cyc[i] : -1, exp_q[i], i);
            end
        end
    endtask

    task automatic test_accumulator();
        v_op[0] = 3'd3; v_a[0] = 8'h05; v_b[0] = 8'h03; v_ua[0] = 0; v_ac[0] = 1;
        v_op[1] = 3'd3; v_a[1] = 8'h30; v_b[1] = 8'h02; v_ua[1] = 1; v_ac[1] = 0;
        v_op[2] = 3'd6; v_a[2] = 8'h11; v_b[2] = 8'h00; v_ua[2] = 1; v_ac[2] = 0;
        v_op[3] = 3'd3; v_a[3] = 8'h40; v_b[3] = 8'h07; v_ua[3] = 1; v_ac[3] = 1;
`ifdef ALU_PIPE_ACC_EN
        exp_q = '{8'h08, 8'h0A, 8'h14, 8'h07};
`else
        exp_q = '{8'h08, 8'h32, 8'h22, 8'h47};
`endif
        run_stream(4, 9);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= got_res.size() || got_res[i] !== exp_q[i] || got_cyc[i] != i + 2) begin
                bad++;
                $display("FAIL acc_chain[%0d]: result=%h cycle=%0d, want %h at %0d", i,
                         (i < got_res.size()) ? got_res[i] : 8'hxx,
                         (i < got_cyc.size()) ? got_cyc[i] : -1, exp_q[i], i + 2);
            end
        end
        // Reset must also zero the accumulator.
        #2;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        tick();
        v_op[0] = 3'd3; v_a[0] = 8'h50; v_b[0] = 8'h01; v_ua[0] = 1; v_ac[0] = 0;
`ifdef ALU_PIPE_ACC_EN
        exp_q = '{8'h01};
`else
        exp_q = '{8'h51};
`endif
        run_stream(1, 5);
        total++;
        if (got_res.size() != 1 || got_res[0] !== exp_q[0]) begin
            bad++;
            $display("FAIL acc_reset: count=%0d result=%h, want 1 %h", got_res.size(),
                     (got_res.size() > 0) ? got_res[0] : 8'hxx, exp_q[0]);
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_backpressure();
        test_accumulator();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
